// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage: holds the PC, fetches words from IMEM and hands each one to the decoder.
// Latency: one cycle from the in_imem_ready handshake to out_is_valid, so 2 cycles per instruction at best.
// Backpressure: out_is is held until in_accept and no new request is issued meanwhile; a slow IMEM holds out_pc stable.
//
// Ports:
//   in_clk, in_rst_n                  clock (rising edge), async active-low reset
//   out_imem_req/out_pc               fetch request, word-aligned byte address
//   in_imem_ready/in_imem_data        IMEM returns the word this cycle
//   out_is/out_is_valid               latched instruction to the decoder
//   in_accept + redirect controls     decoder retires the instruction; selects the next PC
//   in_irq/out_irq_ack/out_epc_save   interrupt entry, return address for CP0
//   in_halt/out_halted                permanent stop, left only by reset
// Optional: define FETCH_PERF_COUNT_EN to add the out_cycle_cnt/out_inst_cnt counters.

module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] IRQ_VECTOR = 32'h0000_0800
) (
   input  logic        in_clk,
   input  logic        in_rst_n,
   output logic        out_imem_req,
   output logic [31:0] out_pc,
   input  logic        in_imem_ready,
   input  logic [31:0] in_imem_data,
   output logic [31:0] out_is,
   output logic        out_is_valid,
   input  logic        in_accept,
   input  logic        in_J,
   input  logic        in_JR,
   input  logic        in_BEQ,
   input  logic        in_BNE,
   input  logic        in_BGEZ,
   input  logic        in_equal,
   input  logic [31:0] in_rs_data,
   input  logic        in_eret,
   input  logic [31:0] in_epc,
   input  logic        in_irq,
   output logic        out_irq_ack,
   output logic [31:0] out_epc_save,
   input  logic        in_halt,
   output logic        out_halted
`ifdef FETCH_PERF_COUNT_EN
  ,output logic [31:0] out_cycle_cnt,
   output logic [31:0] out_inst_cnt
`endif
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]  state;
   logic [31:0] p4;
   logic [31:0] br_off;
   logic        br_taken;
   logic [31:0] next_pc;
   logic        fetch_done;
   logic        retire;
   logic        take_irq;

   assign p4     = out_pc + 32'd4;
   assign br_off = {{14{out_is[15]}}, out_is[15:0], 2'b00};

   assign br_taken = (in_BEQ  &&  in_equal) ||
                     (in_BNE  && !in_equal) ||
                     (in_BGEZ && !in_rs_data[31]);

   // out_imem_req is registered and low for the first cycle after reset, so a
   // ready left over from a request abandoned by reset cannot complete a fetch.
   assign fetch_done = (state == S_REQ) && out_imem_req && in_imem_ready;
   assign retire     = (state == S_HOLD) && in_accept;
   // Halt has priority over an interrupt arriving with the same instruction.
   assign take_irq   = retire && in_irq && !in_halt;

   always_comb begin
      next_pc = p4;
      if (in_irq)
         next_pc = IRQ_VECTOR;
      else if (in_eret)
         next_pc = in_epc;
      else if (in_JR)
         next_pc = in_rs_data;
      else if (in_J)
         next_pc = {p4[31:28], out_is[25:0], 2'b00};
      else if (br_taken)
         next_pc = p4 + br_off;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state        <= S_REQ;
         out_pc       <= RESET_PC;
         out_is       <= 32'd0;
         out_is_valid <= 1'b0;
         out_imem_req <= 1'b0;
         out_irq_ack  <= 1'b0;
         out_epc_save <= 32'd0;
         out_halted   <= 1'b0;
      end else begin
         out_irq_ack <= take_irq;
         if (take_irq)
            out_epc_save <= p4;

         case (state)
            S_REQ: begin
               out_imem_req <= 1'b1;
               if (fetch_done) begin
                  out_is       <= in_imem_data;
                  out_is_valid <= 1'b1;
                  out_imem_req <= 1'b0;
                  state        <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (in_accept) begin
                  out_is_valid <= 1'b0;
                  if (in_halt) begin
                     out_halted <= 1'b1;
                     state      <= S_HALT;
                  end else begin
                     out_pc       <= next_pc;
                     out_imem_req <= 1'b1;
                     state        <= S_REQ;
                  end
               end
            end
            S_HALT: begin
               out_imem_req <= 1'b0;
               out_is_valid <= 1'b0;
            end
            default: begin
               out_imem_req <= 1'b0;
               state        <= S_REQ;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_cycle_cnt <= 32'd0;
         out_inst_cnt  <= 32'd0;
      end else begin
         if (state != S_HALT)
            out_cycle_cnt <= out_cycle_cnt + 32'd1;
         if (retire)
            out_inst_cnt <= out_inst_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: walks the PC through sequential, branch, jump,
// interrupt, eret, wrap, halt and reset-abort cases against a PC/instruction scoreboard.
`timescale 1ns/1ps

module tb_fetch_pc_unit;

   logic        in_clk;
   logic        in_rst_n;
   logic        out_imem_req;
   logic [31:0] out_pc;
   logic        in_imem_ready;
   logic [31:0] in_imem_data;
   logic [31:0] out_is;
   logic        out_is_valid;
   logic        in_accept;
   logic        in_J, in_JR, in_BEQ, in_BNE, in_BGEZ, in_equal;
   logic [31:0] in_rs_data;
   logic        in_eret;
   logic [31:0] in_epc;
   logic        in_irq;
   logic        out_irq_ack;
   logic [31:0] out_epc_save;
   logic        in_halt;
   logic        out_halted;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] out_cycle_cnt;
   logic [31:0] out_inst_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] pc_q[$];
   logic [31:0] is_q[$];

   fetch_pc_unit dut (
      .in_clk        (in_clk),
      .in_rst_n      (in_rst_n),
      .out_imem_req  (out_imem_req),
      .out_pc        (out_pc),
      .in_imem_ready (in_imem_ready),
      .in_imem_data  (in_imem_data),
      .out_is        (out_is),
      .out_is_valid  (out_is_valid),
      .in_accept     (in_accept),
      .in_J          (in_J),
      .in_JR         (in_JR),
      .in_BEQ        (in_BEQ),
      .in_BNE        (in_BNE),
      .in_BGEZ       (in_BGEZ),
      .in_equal      (in_equal),
      .in_rs_data    (in_rs_data),
      .in_eret       (in_eret),
      .in_epc        (in_epc),
      .in_irq        (in_irq),
      .out_irq_ack   (out_irq_ack),
      .out_epc_save  (out_epc_save),
      .in_halt       (in_halt),
      .out_halted    (out_halted)
`ifdef FETCH_PERF_COUNT_EN
     ,.out_cycle_cnt (out_cycle_cnt),
      .out_inst_cnt  (out_inst_cnt)
`endif
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_ctl();
      in_accept  = 1'b0;
      in_J       = 1'b0;
      in_JR      = 1'b0;
      in_BEQ     = 1'b0;
      in_BNE     = 1'b0;
      in_BGEZ    = 1'b0;
      in_equal   = 1'b0;
      in_rs_data = 32'd0;
      in_eret    = 1'b0;
      in_epc     = 32'd0;
      in_irq     = 1'b0;
      in_halt    = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!out_imem_req && n < 20) begin
         @(negedge in_clk);
         n++;
      end
      if (!out_imem_req)
         check_eq("req_timeout", 32'd0, 32'd1);
   endtask

   // Complete one fetch: check the requested PC against the scoreboard, keep
   // IMEM busy for 'delay' cycles, then return 'word' and check it is latched.
   task automatic do_fetch(input logic [31:0] word, input int delay);
      logic [31:0] pc_seen;
      wait_req();
      pc_seen = out_pc;
      if (pc_q.size() == 0)
         check_eq("sb_underflow", 32'd1, 32'd0);
      else
         check_eq("pc", pc_seen, pc_q.pop_front());
      check_eq("valid_low", {31'd0, out_is_valid}, 32'd0);
      for (int i = 0; i < delay; i++) begin
         @(negedge in_clk);
         check_eq("req_held", {31'd0, out_imem_req}, 32'd1);
         check_eq("pc_stable", out_pc, pc_seen);
         check_eq("valid_wait", {31'd0, out_is_valid}, 32'd0);
      end
      in_imem_ready = 1'b1;
      in_imem_data  = word;
      is_q.push_back(word);
      @(negedge in_clk);
      in_imem_ready = 1'b0;
      check_eq("valid_set", {31'd0, out_is_valid}, 32'd1);
      check_eq("is", out_is, is_q.pop_front());
   endtask

   // Retire the held instruction with whatever controls the caller set up.
   task automatic accept_ins(input logic [31:0] exp_next, input bit push);
      in_accept = 1'b1;
      if (push)
         pc_q.push_back(exp_next);
      @(negedge in_clk);
      clear_ctl();
      check_eq("valid_clr", {31'd0, out_is_valid}, 32'd0);
      if (push)
         check_eq("req_b2b", {31'd0, out_imem_req}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      in_rst_n      = 1'b0;
      in_imem_ready = 1'b0;
      in_imem_data  = 32'd0;
      clear_ctl();
      repeat (2) @(negedge in_clk);
      check_eq("rst_pc",      out_pc, 32'h0);
      check_eq("rst_is",      out_is, 32'h0);
      check_eq("rst_valid",   {31'd0, out_is_valid}, 32'd0);
      check_eq("rst_req",     {31'd0, out_imem_req}, 32'd0);
      check_eq("rst_ack",     {31'd0, out_irq_ack}, 32'd0);
      check_eq("rst_epc",     out_epc_save, 32'd0);
      check_eq("rst_halted",  {31'd0, out_halted}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
      check_eq("rst_cyc",     out_cycle_cnt, 32'd0);
      check_eq("rst_inst",    out_inst_cnt, 32'd0);
`endif
      in_rst_n = 1'b1;
      pc_q.push_back(32'h0);

      // sequential fetch, IMEM always ready
      do_fetch(32'h0, 0);  accept_ins(32'h4, 1);
      do_fetch(32'h0, 0);  accept_ins(32'h8, 1);
      do_fetch(32'h0, 0);  accept_ins(32'hC, 1);
      do_fetch(32'h0, 0);  accept_ins(32'h10, 1);
      // slow IMEM at 0x10
      do_fetch(32'h0, 3);  accept_ins(32'h14, 1);
      do_fetch(32'h0, 0);  in_JR = 1'b1; in_rs_data = 32'h20; accept_ins(32'h20, 1);
      // BEQ imm -2 taken / not taken
      do_fetch(32'h1000_FFFE, 0); in_BEQ = 1'b1; in_equal = 1'b1; accept_ins(32'h1C, 1);
      do_fetch(32'h0, 0);  in_JR = 1'b1; in_rs_data = 32'h20; accept_ins(32'h20, 1);
      do_fetch(32'h1000_FFFE, 0); in_BEQ = 1'b1; in_equal = 1'b0; accept_ins(32'h24, 1);
      // BNE taken when not equal
      do_fetch(32'h1400_FFFE, 0); in_BNE = 1'b1; in_equal = 1'b0; accept_ins(32'h20, 1);
      // BGEZ: negative rs not taken, then positive rs taken (imm 3)
      do_fetch(32'h0401_0003, 0); in_BGEZ = 1'b1; in_rs_data = 32'h8000_0000; accept_ins(32'h24, 1);
      do_fetch(32'h0401_0003, 0); in_BGEZ = 1'b1; in_rs_data = 32'h0000_0001; accept_ins(32'h34, 1);
      // J / JR
      do_fetch(32'h0800_0010, 0); in_J = 1'b1; accept_ins(32'h40, 1);
      do_fetch(32'h0800_0040, 0); in_J = 1'b1; accept_ins(32'h100, 1);
      do_fetch(32'h0, 0);  in_JR = 1'b1; in_rs_data = 32'h300; accept_ins(32'h300, 1);
      do_fetch(32'h0, 0);  in_JR = 1'b1; in_rs_data = 32'h50; accept_ins(32'h50, 1);
      // irq beats eret
      do_fetch(32'h0, 0);  in_irq = 1'b1; in_eret = 1'b1; in_epc = 32'h1234; accept_ins(32'h800, 1);
      check_eq("irq_ack", {31'd0, out_irq_ack}, 32'd1);
      check_eq("epc_save", out_epc_save, 32'h54);
      @(negedge in_clk);
      check_eq("irq_ack_pulse", {31'd0, out_irq_ack}, 32'd0);
      // eret returns to in_epc; epc_save untouched
      do_fetch(32'h0, 0);  in_eret = 1'b1; in_epc = 32'h60; accept_ins(32'h60, 1);
      check_eq("epc_hold", out_epc_save, 32'h54);
      // PC wrap
      do_fetch(32'h0, 0);  in_JR = 1'b1; in_rs_data = 32'hFFFF_FFFC; accept_ins(32'hFFFF_FFFC, 1);
      do_fetch(32'h0, 0);  accept_ins(32'h0, 1);
      // halt together with irq: halt wins
      do_fetch(32'h0, 0);  in_halt = 1'b1; in_irq = 1'b1; accept_ins(32'h0, 0);
      check_eq("halted", {31'd0, out_halted}, 32'd1);
      check_eq("halt_no_ack", {31'd0, out_irq_ack}, 32'd0);
      check_eq("halt_epc", out_epc_save, 32'h54);
      for (int i = 0; i < 3; i++) begin
         in_imem_ready = 1'b1;
         @(negedge in_clk);
         check_eq("halt_no_req", {31'd0, out_imem_req}, 32'd0);
         check_eq("halt_valid", {31'd0, out_is_valid}, 32'd0);
      end
      in_imem_ready = 1'b0;

      // reset leaves halt
      in_rst_n = 1'b0;
      #1 check_eq("rst2_halted", {31'd0, out_halted}, 32'd0);
      @(negedge in_clk);
      in_rst_n = 1'b1;
      pc_q.push_back(32'h0);
      do_fetch(32'h0, 0);  accept_ins(32'h4, 1);
      // reset mid-request at 0x4, late IMEM data ignored
      wait_req();
      check_eq("pc", out_pc, pc_q.pop_front());
      @(negedge in_clk);
      in_rst_n = 1'b0;
      #1;
      check_eq("rst3_pc", out_pc, 32'h0);
      check_eq("rst3_req", {31'd0, out_imem_req}, 32'd0);
      @(negedge in_clk);
      in_rst_n      = 1'b1;
      in_imem_ready = 1'b1;
      in_imem_data  = 32'hDEAD_BEEF;
      @(negedge in_clk);
      in_imem_ready = 1'b0;
      check_eq("late_data", {31'd0, out_is_valid}, 32'd0);
      pc_q.push_back(32'h0);
      do_fetch(32'h2400_0001, 0); accept_ins(32'h4, 1);
`ifdef FETCH_PERF_COUNT_EN
      check_eq("inst_cnt", out_inst_cnt, 32'd1);
`endif
      do_fetch(32'h0, 0);
      check_eq("sb_empty", pc_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and requests words from instruction memory over a ready handshake.
- Presents each fetched word, with a valid flag, to the decoder.
- Computes the next PC from the decoder's jump/branch/eret controls, the rs comparison results, and an external interrupt. Stops permanently on a halt request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IRQ_VECTOR, 32'h0000_0800, PC loaded on interrupt entry.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- out_imem_req  output  1  fetch request, address on out_pc.
- out_pc  output  32  current PC / IMEM word address (byte address, bits[1:0]=0).
- in_imem_ready  input  1  IMEM returns in_imem_data this cycle.
- in_imem_data  input  32  fetched instruction word.
- out_is  output  32  latched instruction to the decoder.
- out_is_valid  output  1  out_is holds a valid instruction.
- in_accept  input  1  decode/execute completes the current instruction this cycle; all redirect inputs are valid in this cycle.
- in_J  input  1  J or JAL.
- in_JR  input  1  JR or JALR.
- in_BEQ  input  1  BEQ.
- in_BNE  input  1  BNE.
- in_BGEZ  input  1  BGEZ.
- in_equal  input  1  rs==rt.
- in_rs_data  input  32  rs value (JR target, BGEZ sign).
- in_eret  input  1  ERET.
- in_epc  input  32  return PC from CP0.
- in_irq  input  1  interrupt pending (already masked by CP0).
- out_irq_ack  output  1  one-cycle pulse; interrupt taken, epc = out_epc_save.
- out_epc_save  output  32  PC+4 of the accepted instruction.
- in_halt  input  1  halt request (syscall exit), qualified with in_accept.
- out_halted  output  1  fetch stopped.

Behaviour:
- Reset (async, in_rst_n=0):
  - out_pc=RESET_PC, out_is=0, out_is_valid=0, out_imem_req=0, out_irq_ack=0, out_epc_save=0, out_halted=0.
  - FSM goes to S_REQ.
  - Reset during an outstanding request abandons it; late IMEM data is ignored.
- S_REQ:
  - out_imem_req=1.
  - On in_imem_ready: latch out_is=in_imem_data, set out_is_valid=1, go to S_HOLD at the next edge.
  - Otherwise stay in S_REQ; out_pc is stable.
- S_HOLD:
  - out_is and out_is_valid stay stable until in_accept.
  - On in_accept: load the new PC, clear out_is_valid, go to S_REQ. If in_halt is also set, go to S_HALT instead.
- S_HALT:
  - out_halted=1, no requests, out_is_valid=0.
  - Only reset exits.
- in_accept and in_halt are ignored outside S_HOLD.
- Next PC, with p4=out_pc+4 (32-bit wrap), highest priority first:
  1. in_irq: IRQ_VECTOR; pulse out_irq_ack; out_epc_save=p4.
  2. in_eret: in_epc.
  3. in_JR: in_rs_data.
  4. in_J: {p4[31:28], out_is[25:0], 2'b00}.
  5. Taken branch: p4 + (sign-extended out_is[15:0] << 2).
     - BEQ is taken when in_equal=1.
     - BNE is taken when in_equal=0.
     - BGEZ is taken when in_rs_data[31]=0.
  6. Otherwise: p4.
- Simultaneous in_halt and in_irq at accept: halt wins; no irq_ack.
- out_epc_save updates only when an interrupt is taken.
- PC 32'hFFFF_FFFC + 4 wraps to 0.
- Minimum throughput: 2 cycles per instruction when IMEM is ready immediately.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined: adds out_cycle_cnt (32) and out_inst_cnt (32).
  - Both reset to 0.
  - out_cycle_cnt increments every cycle not in S_HALT.
  - out_inst_cnt increments on each in_accept in S_HOLD.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, IMEM always ready, in_accept held 1 → out_pc sequence 0x0, 0x4, 0x8; out_is_valid high every second cycle.
- IMEM ready delayed 3 cycles at PC 0x10 → out_imem_req held, out_pc stays 0x10, out_is_valid rises 1 cycle after ready.
- out_is=0x1000FFFE (BEQ, imm -2) at PC 0x20:
  - in_equal=1 → next PC 0x1C.
  - in_equal=0 → next PC 0x24.
- J 0x08000040 at PC 0x40 → next PC 0x100. JR with in_rs_data=0x300 → 0x300.
- in_irq and in_eret together at accept, PC 0x50 → PC 0x800, out_irq_ack pulse, out_epc_save=0x54.
- in_halt at accept → out_halted=1, no further requests; in_rst_n pulse low mid-S_REQ → PC 0x0 and normal fetch restarts.
